// File: rtl/period_channel_arbiter.sv
// Two-channel period result arbiter: captures EDGE_FLAG/DURATION pairs,
// holds one result per channel and serves them round-robin on one stream.
module period_channel_arbiter #(
  parameter int COUNTER_BITS      = 16,
  parameter int OVERSAMPLING_BITS = 3,
  parameter int TIMEOUT_CYCLES    = 1000000
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic                                    EDGE_FLAG_0,
  input  logic [COUNTER_BITS+OVERSAMPLING_BITS-1:0] DURATION_0,
  input  logic                                    EDGE_FLAG_1,
  input  logic [COUNTER_BITS+OVERSAMPLING_BITS-1:0] DURATION_1,
  output logic                                    OUT_VALID,
  input  logic                                    OUT_READY,
  output logic                                    OUT_CHANNEL,
  output logic [COUNTER_BITS+OVERSAMPLING_BITS-1:0] OUT_DURATION,
  input  logic                                    CLEAR_FLAGS,
  output logic [1:0]                              OVERRUN,
  output logic [1:0]                              NO_SIGNAL
);

  localparam int W  = COUNTER_BITS + OVERSAMPLING_BITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  logic [1:0]          edge_flag;
  logic [1:0]          capture;

  logic [1:0]          prev_q, prev_d;
  logic [1:0]          pend_q, pend_d;
  logic [1:0][W-1:0]   hold_q, hold_d;
  logic                last_q, last_d;

  logic                out_valid_q, out_valid_d;
  logic                out_ch_q, out_ch_d;
  logic [W-1:0]        out_dur_q, out_dur_d;

  logic [1:0]          ovr_q, ovr_d;
  logic [1:0]          new_ovr;
  logic [1:0]          nosig_q, nosig_d;
  logic [1:0][TW-1:0]  cnt_q, cnt_d;

  logic                slot_free;
  logic                gnt_vld;
  logic                gnt_ch;
  logic [1:0]          gnt_hit;

  assign edge_flag = {EDGE_FLAG_1, EDGE_FLAG_0};

  // Rising-edge detect so a level-held flag yields a single capture.
  always_comb begin
    prev_d  = edge_flag;
    capture = edge_flag & ~prev_q;
  end

  // Round-robin grant on registered pend bits, only when the slot frees up.
  always_comb begin
    slot_free = ~out_valid_q | OUT_READY;
    gnt_vld   = 1'b0;
    gnt_ch    = 1'b0;
    if (slot_free) begin
      unique case (1'b1)
        (pend_q == 2'b01): begin
          gnt_vld = 1'b1;
          gnt_ch  = 1'b0;
        end
        (pend_q == 2'b10): begin
          gnt_vld = 1'b1;
          gnt_ch  = 1'b1;
        end
        (pend_q == 2'b11): begin
          gnt_vld = 1'b1;
          gnt_ch  = ~last_q;
        end
        default: begin
          gnt_vld = 1'b0;
          gnt_ch  = 1'b0;
        end
      endcase
    end
    gnt_hit = gnt_vld ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00;
  end

  // Pending registers, output word and overrun flags.
  always_comb begin
    hold_d      = hold_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_dur_d   = out_dur_q;

    if (slot_free) begin
      out_valid_d = gnt_vld;
    end
    if (gnt_vld) begin
      out_dur_d = hold_q[gnt_ch];
      out_ch_d  = gnt_ch;
      last_d    = gnt_ch;
    end

    // A capture on a granted channel refills it; the old value left above.
    if (capture[0]) begin
      hold_d[0] = DURATION_0;
    end
    if (capture[1]) begin
      hold_d[1] = DURATION_1;
    end
    pend_d = (pend_q & ~gnt_hit) | capture;

    // Only an unserved pending value being replaced counts as lost.
    new_ovr = capture & pend_q & ~gnt_hit;
    ovr_d   = (ovr_q & ~{2{CLEAR_FLAGS}}) | new_ovr;
  end

  // Per-channel silence timers, saturating at the timeout.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      if (capture[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == T_MAX) begin
        cnt_d[n] = T_MAX;
      end else begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
      nosig_d[n] = (cnt_d[n] == T_MAX);
    end
  end

  // State update; reset drops any word still on the output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q      <= '0;
      pend_q      <= '0;
      hold_q      <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_ch_q    <= 1'b0;
      out_dur_q   <= '0;
      ovr_q       <= '0;
      nosig_q     <= '0;
      cnt_q       <= '0;
    end else begin
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_dur_q   <= out_dur_d;
      ovr_q       <= ovr_d;
      nosig_q     <= nosig_d;
      cnt_q       <= cnt_d;
    end
  end

  assign OUT_VALID    = out_valid_q;
  assign OUT_CHANNEL  = out_ch_q;
  assign OUT_DURATION = out_dur_q;
  assign OVERRUN      = ovr_q;
  assign NO_SIGNAL    = nosig_q;

endmodule

// File: tb/tb_period_channel_arbiter.sv
// Scoreboard bench for period_channel_arbiter: directed scenarios then
// random traffic, checked against a mailbox-style reference model.
module tb_period_channel_arbiter;

  localparam int CB = 16;
  localparam int OB = 3;
  localparam int W  = CB + OB;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         RESET;
  logic         EDGE_FLAG_0, EDGE_FLAG_1;
  logic [W-1:0] DURATION_0, DURATION_1;
  logic         OUT_VALID, OUT_READY, OUT_CHANNEL;
  logic [W-1:0] OUT_DURATION;
  logic         CLEAR_FLAGS;
  logic [1:0]   OVERRUN, NO_SIGNAL;

  period_channel_arbiter #(
    .COUNTER_BITS(CB),
    .OVERSAMPLING_BITS(OB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk),
    .RESET(RESET),
    .EDGE_FLAG_0(EDGE_FLAG_0),
    .DURATION_0(DURATION_0),
    .EDGE_FLAG_1(EDGE_FLAG_1),
    .DURATION_1(DURATION_1),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_CHANNEL(OUT_CHANNEL),
    .OUT_DURATION(OUT_DURATION),
    .CLEAR_FLAGS(CLEAR_FLAGS),
    .OVERRUN(OVERRUN),
    .NO_SIGNAL(NO_SIGNAL)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_words = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: each channel is a one-slot mailbox; the output is a
  // single presented word; ties go to whoever was not served last.
  logic [W:0]   exp_q[$];
  bit           mb_full[2]  = '{0, 0};
  logic [W-1:0] mb_val[2]   = '{'0, '0};
  bit           flag_seen[2] = '{0, 0};
  int           served_last = 1;
  bit           m_valid     = 0;
  logic [1:0]   m_ovr       = 2'b00;
  int           quiet[2]    = '{0, 0};
  logic [1:0]   m_nosig     = 2'b00;

  always @(posedge clk) begin
    bit rise[2];
    bit lost[2];
    int pick;
    if (RESET) begin
      mb_full = '{0, 0};
      mb_val = '{'0, '0};
      flag_seen = '{0, 0};
      served_last = 1;
      m_valid = 0;
      m_ovr = 2'b00;
      quiet = '{0, 0};
      m_nosig = 2'b00;
      exp_q.delete();
    end else begin
      rise[0] = EDGE_FLAG_0 && !flag_seen[0];
      rise[1] = EDGE_FLAG_1 && !flag_seen[1];
      flag_seen[0] = EDGE_FLAG_0;
      flag_seen[1] = EDGE_FLAG_1;
      pick = -1;
      if (!m_valid || OUT_READY) begin
        if (mb_full[0] && mb_full[1]) pick = 1 - served_last;
        else if (mb_full[0]) pick = 0;
        else if (mb_full[1]) pick = 1;
        m_valid = (pick >= 0);
        if (pick >= 0) begin
          exp_q.push_back({pick[0], mb_val[pick]});
          mb_full[pick] = 0;
          served_last = pick;
        end
      end
      if (CLEAR_FLAGS) m_ovr = 2'b00;
      lost[0] = rise[0] && mb_full[0];
      lost[1] = rise[1] && mb_full[1];
      if (lost[0]) m_ovr[0] = 1'b1;
      if (lost[1]) m_ovr[1] = 1'b1;
      if (rise[0]) begin mb_full[0] = 1; mb_val[0] = DURATION_0; end
      if (rise[1]) begin mb_full[1] = 1; mb_val[1] = DURATION_1; end
      for (int n = 0; n < 2; n++) begin
        if (rise[n]) quiet[n] = 0;
        else if (quiet[n] < TO) quiet[n]++;
        m_nosig[n] = (quiet[n] == TO);
      end
    end
  end

  // Monitor: compare presented word and flags on the falling edge.
  always @(negedge clk) begin
    chk("out_valid", OUT_VALID, m_valid);
    chk("overrun", OVERRUN, m_ovr);
    chk("no_signal", NO_SIGNAL, m_nosig);
    if (OUT_VALID && OUT_READY) n_words++;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard: model word missing at %0t", $time);
      end else begin
        chk("out_channel", OUT_CHANNEL, exp_q[0][W]);
        chk("out_duration", OUT_DURATION, exp_q[0][W-1:0]);
        if (OUT_READY) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int ch, input logic [W-1:0] d);
    if (ch == 0) begin EDGE_FLAG_0 = 1; DURATION_0 = d; end
    else begin EDGE_FLAG_1 = 1; DURATION_1 = d; end
    tick();
    EDGE_FLAG_0 = 0;
    EDGE_FLAG_1 = 0;
    tick();
  endtask

  initial begin
    int w0;
    RESET = 1; EDGE_FLAG_0 = 0; EDGE_FLAG_1 = 0;
    DURATION_0 = '0; DURATION_1 = '0;
    OUT_READY = 0; CLEAR_FLAGS = 0;
    tick(); tick();
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_channel", OUT_CHANNEL, 0);
    chk("rst_duration", OUT_DURATION, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_nosig", NO_SIGNAL, 0);
    RESET = 0;

    // Timeout from reset release, then a single capture clears ch1
    repeat (TO - 1) tick();
    chk("nosig_early", NO_SIGNAL, 2'b00);
    tick();
    chk("nosig_timeout", NO_SIGNAL, 2'b11);
    OUT_READY = 1;
    EDGE_FLAG_1 = 1; DURATION_1 = 19'h05555;
    tick();
    chk("nosig_clear", NO_SIGNAL, 2'b01);
    EDGE_FLAG_1 = 0;
    repeat (3) tick();

    // Simultaneous edges: alternating fair order
    repeat (2) begin
      EDGE_FLAG_0 = 1; DURATION_0 = 19'h00100;
      EDGE_FLAG_1 = 1; DURATION_1 = 19'h00200;
      tick();
      EDGE_FLAG_0 = 0; EDGE_FLAG_1 = 0;
      tick();
      chk("sim_first_ch", OUT_CHANNEL, 0);
      chk("sim_first_dur", OUT_DURATION, 19'h00100);
      tick();
      chk("sim_second_ch", OUT_CHANNEL, 1);
      chk("sim_second_dur", OUT_DURATION, 19'h00200);
      tick();
    end

    // Single result, two-cycle latency
    EDGE_FLAG_0 = 1; DURATION_0 = 19'h1A2B3;
    tick();
    chk("lat_not_yet", OUT_VALID, 0);
    EDGE_FLAG_0 = 0;
    tick();
    chk("lat_valid", OUT_VALID, 1);
    chk("lat_dur", OUT_DURATION, 19'h1A2B3);
    tick();
    chk("lat_one_cycle", OUT_VALID, 0);
    chk("lat_overrun", OVERRUN, 0);

    // Backpressure and overrun
    OUT_READY = 0;
    pulse(0, 19'h00111);
    chk("bp_held", OUT_DURATION, 19'h00111);
    pulse(0, 19'h00222);
    pulse(0, 19'h00333);
    chk("bp_overrun", OVERRUN, 2'b01);
    chk("bp_stable", OUT_DURATION, 19'h00111);
    OUT_READY = 1;
    tick();
    chk("bp_second", OUT_DURATION, 19'h00333);
    tick();
    CLEAR_FLAGS = 1;
    tick();
    CLEAR_FLAGS = 0;
    chk("bp_clear", OVERRUN, 2'b00);

    // Level-held flag yields one word
    w0 = n_words;
    EDGE_FLAG_1 = 1; DURATION_1 = 19'h00444;
    repeat (5) tick();
    EDGE_FLAG_1 = 0;
    repeat (4) tick();
    chk("level_words", n_words - w0, 1);

    // Reset mid-transfer
    OUT_READY = 0;
    pulse(0, 19'h00555);
    pulse(1, 19'h00666);
    RESET = 1;
    tick();
    RESET = 0;
    chk("mid_valid", OUT_VALID, 0);
    chk("mid_channel", OUT_CHANNEL, 0);
    chk("mid_duration", OUT_DURATION, 0);
    w0 = n_words;
    OUT_READY = 1;
    repeat (5) tick();
    chk("mid_no_stale", n_words - w0, 0);

    // Random traffic with quiet windows and rare resets
    for (int i = 0; i < 3000; i++) begin
      bool_quiet: begin end
      if ((i / 150) % 3 != 1 && $urandom_range(0, 3) == 0)
        EDGE_FLAG_0 = ~EDGE_FLAG_0;
      if ($urandom_range(0, 3) == 0) EDGE_FLAG_1 = ~EDGE_FLAG_1;
      DURATION_0 = W'($urandom);
      DURATION_1 = W'($urandom);
      OUT_READY = ($urandom_range(0, 2) != 0);
      CLEAR_FLAGS = ($urandom_range(0, 15) == 0);
      RESET = ($urandom_range(0, 699) == 0);
      tick();
    end
    RESET = 0; CLEAR_FLAGS = 0;
    EDGE_FLAG_0 = 0; EDGE_FLAG_1 = 0;
    OUT_READY = 1;
    repeat (10) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
